// File: rtl/prog_mem_fetch_if.sv
// Instruction bus between the fetch sequencer and the CPU decode stage.
// master : the fetch sequencer; drives the instruction fields and instr_valid.
// slave  : the consumer; drives instr_ready.
//   instr_valid    instruction is being presented
//   instr_ready    consumer accepts when instr_valid & instr_ready at a clock edge
//   instr_op       opcode word
//   instr_imm      immediate word (0 when instr_has_imm = 0)
//   instr_has_imm  instruction carried an immediate
//   instr_pc       address of the opcode word
interface prog_mem_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_op;
  logic [DATA_W-1:0] instr_imm;
  logic              instr_has_imm;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output instr_valid, instr_op, instr_imm, instr_has_imm, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_imm, instr_has_imm, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/prog_mem_fetch.sv
// Loadable program memory with an instruction-fetch sequencer.
// A loader writes the program while ld_en is high; after start the sequencer
// fetches an opcode word and, when the opcode calls for one, the following
// immediate word, then presents the whole instruction on ibus until it is
// accepted. redirect restarts fetching at a new address; accepting a HALT
// opcode stops the sequencer and raises halted.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   ld_en, ld_we          load mode / write strobe (write only while ld_en)
//   ld_addr, ld_data      load address and data
//   start, start_pc       begin fetching at start_pc from IDLE or HALTED
//   redirect, redirect_pc abort the current fetch and restart at redirect_pc
//   ibus                  instruction bus (master side)
//   halted                HALT accepted, sequencer stopped
module prog_mem_fetch #(
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 8,
  parameter int              DEPTH     = 256,
  parameter logic [DATA_W-1:0] HALT_WORD = 'h30,
  parameter logic [3:0]      HALT_OPC  = 4'd3,
  parameter logic [3:0]      NOIMM_OPC = 4'd7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  prog_mem_fetch_if.master  ibus,
  output logic              halted
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH_OP  = 3'd1;
  localparam logic [2:0] S_FETCH_IMM = 3'd2;
  localparam logic [2:0] S_PRESENT   = 3'd3;
  localparam logic [2:0] S_HALTED    = 3'd4;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_plus2;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic              rd_has_imm;
  logic              op_is_halt;
  logic              can_redirect;

  assign pc_plus1 = pc + ADDR_W'(1);
  assign pc_plus2 = pc + ADDR_W'(2);

  // The immediate sits right after the opcode and wraps with the address space.
  assign rd_addr = (state == S_FETCH_IMM) ? pc_plus1 : pc;

  assign rd_has_imm = (rd_word[1:0] == 2'b00) &&
                      (rd_word[DATA_W-1 -: 4] != HALT_OPC) &&
                      (rd_word[DATA_W-1 -: 4] != NOIMM_OPC);

  assign op_is_halt   = (ibus.instr_op[DATA_W-1 -: 4] == HALT_OPC);
  assign can_redirect = (state != S_IDLE) && (state != S_HALTED);

  assign ibus.instr_valid = (state == S_PRESENT);

  // Words beyond the implemented depth read back as HALT so a runaway PC stops.
  // The word is only consumed by registers at the end of a fetch cycle, so the
  // memory behaves as a synchronous read with one cycle per word.
  always_comb begin
    rd_word = HALT_WORD;
    if (32'(rd_addr) < DEPTH) begin
      rd_word = mem[rd_addr[IDX_W-1:0]];
    end
  end

  // Loader write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en && ld_we && (32'(ld_addr) < DEPTH)) begin
      mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end

  // Fetch sequencer. Priority: rst, then load mode, then redirect, then the
  // normal state flow. A redirect in PRESENT also discards or completes the
  // presented instruction; either way the next fetch starts at redirect_pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      pc                 <= '0;
      ibus.instr_op      <= '0;
      ibus.instr_imm     <= '0;
      ibus.instr_has_imm <= 1'b0;
      ibus.instr_pc      <= '0;
      halted             <= 1'b0;
    end else if (ld_en) begin
      state  <= S_IDLE;
      halted <= 1'b0;
    end else if (redirect && can_redirect) begin
      pc    <= redirect_pc;
      state <= S_FETCH_OP;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc     <= start_pc;
            halted <= 1'b0;
            state  <= S_FETCH_OP;
          end
        end
        S_FETCH_OP: begin
          ibus.instr_op      <= rd_word;
          ibus.instr_pc      <= pc;
          ibus.instr_has_imm <= rd_has_imm;
          ibus.instr_imm     <= '0;
          state              <= rd_has_imm ? S_FETCH_IMM : S_PRESENT;
        end
        S_FETCH_IMM: begin
          ibus.instr_imm <= rd_word;
          state          <= S_PRESENT;
        end
        S_PRESENT: begin
          if (ibus.instr_ready) begin
            if (op_is_halt) begin
              halted <= 1'b1;
              state  <= S_HALTED;
            end else begin
              pc    <= ibus.instr_has_imm ? pc_plus2 : pc_plus1;
              state <= S_FETCH_OP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_fetch.sv
// Self-checking bench for prog_mem_fetch.
// Three instances share one stimulus bus:
//   dut_a  ADDR_W=8, DEPTH=256  main instance, directed and randomized checks
//   dut_b  ADDR_W=8, DEPTH=16   out-of-range reads
//   dut_c  ADDR_W=4, DEPTH=16   address wrap of the immediate fetch
// ref_mem mirrors what the loader wrote (dut_a, and dut_b below 16);
// ref_mem_c mirrors dut_c, which sees only the low four address bits.
module tb_prog_mem_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_en;
  logic       ld_we;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       start;
  logic [7:0] start_pc;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       instr_ready;
  logic       halted_a;
  logic       halted_b;
  logic       halted_c;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] ref_mem   [256];
  logic [7:0] ref_mem_c [16];

  prog_mem_fetch_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
  prog_mem_fetch_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();
  prog_mem_fetch_if #(.ADDR_W(4), .DATA_W(8)) bus_c ();

  assign bus_a.instr_ready = instr_ready;
  assign bus_b.instr_ready = instr_ready;
  assign bus_c.instr_ready = instr_ready;

  prog_mem_fetch #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .ibus(bus_a),
    .halted(halted_a)
  );

  prog_mem_fetch #(.ADDR_W(8), .DATA_W(8), .DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .ibus(bus_b),
    .halted(halted_b)
  );

  prog_mem_fetch #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut_c (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_we(ld_we),
    .ld_addr(ld_addr[3:0]), .ld_data(ld_data), .start(start),
    .start_pc(start_pc[3:0]), .redirect(redirect),
    .redirect_pc(redirect_pc[3:0]), .ibus(bus_c), .halted(halted_c)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_has_imm(input logic [7:0] w);
    return (w[1:0] == 2'b00) && (w[7:4] != 4'd3) && (w[7:4] != 4'd7);
  endfunction

  function automatic logic valid_of(input int sel);
    if (sel == 0) return bus_a.instr_valid;
    if (sel == 1) return bus_b.instr_valid;
    return bus_c.instr_valid;
  endfunction

  task automatic load_word(input logic [7:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_we = 1'b0;
    ld_en = 1'b0;
    ref_mem[a]        = d;
    ref_mem_c[a[3:0]] = d;
  endtask

  task automatic cleanup();
    start    = 1'b0;
    redirect = 1'b0;
    ld_we    = 1'b0;
    ld_en    = 1'b1;
    step();
    ld_en = 1'b0;
  endtask

  // Steps past the edge that samples a start/redirect/accept, drops the pulses,
  // then counts edges until the chosen instance presents (bounded).
  task automatic count_to_valid(input int sel, output int n);
    step();
    start    = 1'b0;
    redirect = 1'b0;
    n = 1;
    while (!valid_of(sel) && n < 30) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; start_pc = '0; redirect = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0;
    step();
    step();
    tests_run++;
    if (bus_a.instr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", bus_a.instr_valid); end
    tests_run++;
    if (bus_a.instr_op !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_op: got %h expected 00", bus_a.instr_op); end
    tests_run++;
    if (bus_a.instr_imm !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_imm: got %h expected 00", bus_a.instr_imm); end
    tests_run++;
    if (bus_a.instr_has_imm !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_has_imm: got %b expected 0", bus_a.instr_has_imm); end
    tests_run++;
    if (bus_a.instr_pc !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_pc: got %h expected 00", bus_a.instr_pc); end
    tests_run++;
    if (halted_a !== 1'b0 || halted_b !== 1'b0 || halted_c !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_halted: got %b%b%b expected 000", halted_a, halted_b, halted_c);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int n;
    cleanup();
    load_word(8'h00, 8'h08);
    load_word(8'h01, 8'h0F);
    load_word(8'h02, 8'h30);
    instr_ready = 1'b1;
    start_pc = 8'h00;
    start = 1'b1;
    count_to_valid(0, n);
    tests_run++;
    if (n !== 3 || bus_a.instr_op !== 8'h08 || bus_a.instr_imm !== 8'h0F ||
        bus_a.instr_has_imm !== 1'b1 || bus_a.instr_pc !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL basic_first: got lat=%0d op=%h imm=%h has=%b pc=%h expected lat=3 op=08 imm=0F has=1 pc=00",
               n, bus_a.instr_op, bus_a.instr_imm, bus_a.instr_has_imm, bus_a.instr_pc);
    end
    count_to_valid(0, n);
    tests_run++;
    if (n !== 2 || bus_a.instr_op !== 8'h30 || bus_a.instr_imm !== 8'h00 ||
        bus_a.instr_has_imm !== 1'b0 || bus_a.instr_pc !== 8'h02) begin
      tests_failed++;
      $display("[TB] FAIL basic_halt_instr: got lat=%0d op=%h imm=%h has=%b pc=%h expected lat=2 op=30 imm=00 has=0 pc=02",
               n, bus_a.instr_op, bus_a.instr_imm, bus_a.instr_has_imm, bus_a.instr_pc);
    end
    step();
    instr_ready = 1'b0;
    tests_run++;
    if (halted_a !== 1'b1 || bus_a.instr_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL basic_halted: got halted=%b valid=%b expected halted=1 valid=0", halted_a, bus_a.instr_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [7:0] s_op, s_imm, s_pc;
    logic       s_has;
    cleanup();
    load_word(8'h20, 8'h40);
    load_word(8'h21, 8'h55);
    load_word(8'h22, 8'h2D);
    instr_ready = 1'b0;
    start_pc = 8'h20;
    start = 1'b1;
    count_to_valid(0, n);
    s_op = bus_a.instr_op; s_imm = bus_a.instr_imm; s_has = bus_a.instr_has_imm; s_pc = bus_a.instr_pc;
    tests_run++;
    if (n !== 3 || s_op !== 8'h40 || s_imm !== 8'h55 || s_has !== 1'b1 || s_pc !== 8'h20) begin
      tests_failed++;
      $display("[TB] FAIL bp_first: got lat=%0d op=%h imm=%h has=%b pc=%h expected lat=3 op=40 imm=55 has=1 pc=20",
               n, s_op, s_imm, s_has, s_pc);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (bus_a.instr_valid !== 1'b1 || bus_a.instr_op !== s_op || bus_a.instr_imm !== s_imm ||
          bus_a.instr_has_imm !== s_has || bus_a.instr_pc !== s_pc) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold: cycle %0d got valid=%b op=%h imm=%h has=%b pc=%h expected valid=1 op=%h imm=%h has=%b pc=%h",
                 i, bus_a.instr_valid, bus_a.instr_op, bus_a.instr_imm, bus_a.instr_has_imm, bus_a.instr_pc,
                 s_op, s_imm, s_has, s_pc);
      end
    end
    instr_ready = 1'b1;
    count_to_valid(0, n);
    instr_ready = 1'b0;
    tests_run++;
    if (n !== 2 || bus_a.instr_pc !== 8'h22 || bus_a.instr_op !== 8'h2D || bus_a.instr_has_imm !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_next: got lat=%0d pc=%h op=%h has=%b expected lat=2 pc=22 op=2D has=0",
               n, bus_a.instr_pc, bus_a.instr_op, bus_a.instr_has_imm);
    end
  endtask

  task automatic test_redirect();
    int n;
    logic [7:0] e_op;
    cleanup();
    load_word(8'h00, 8'h08);
    load_word(8'h01, 8'h0F);
    load_word(8'h10, 8'h71);
    instr_ready = 1'b1;
    start_pc = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    redirect = 1'b1;
    redirect_pc = 8'h10;
    count_to_valid(0, n);
    tests_run++;
    if (n !== 2 || bus_a.instr_pc !== 8'h10 || bus_a.instr_op !== 8'h71 || bus_a.instr_has_imm !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL redirect_target: got lat=%0d pc=%h op=%h has=%b expected lat=2 pc=10 op=71 has=0",
               n, bus_a.instr_pc, bus_a.instr_op, bus_a.instr_has_imm);
    end
    count_to_valid(0, n);
    instr_ready = 1'b0;
    e_op = ref_mem[8'h11];
    tests_run++;
    if (bus_a.instr_pc !== 8'h11 || bus_a.instr_op !== e_op) begin
      tests_failed++;
      $display("[TB] FAIL redirect_next: got pc=%h op=%h expected pc=11 op=%h", bus_a.instr_pc, bus_a.instr_op, e_op);
    end
  endtask

  task automatic test_out_of_range();
    int n;
    cleanup();
    instr_ready = 1'b0;
    start_pc = 8'd20;
    start = 1'b1;
    count_to_valid(1, n);
    tests_run++;
    if (n !== 2 || bus_b.instr_op !== 8'h30 || bus_b.instr_has_imm !== 1'b0 ||
        bus_b.instr_imm !== 8'h00 || bus_b.instr_pc !== 8'd20) begin
      tests_failed++;
      $display("[TB] FAIL oor_word: got lat=%0d op=%h has=%b imm=%h pc=%h expected lat=2 op=30 has=0 imm=00 pc=14",
               n, bus_b.instr_op, bus_b.instr_has_imm, bus_b.instr_imm, bus_b.instr_pc);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    tests_run++;
    if (halted_b !== 1'b1 || bus_b.instr_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL oor_halted: got halted=%b valid=%b expected halted=1 valid=0", halted_b, bus_b.instr_valid);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [7:0] e_op;
    cleanup();
    load_word(8'd15, 8'h04);
    load_word(8'd0, 8'h07);
    instr_ready = 1'b0;
    start_pc = 8'd15;
    start = 1'b1;
    count_to_valid(2, n);
    tests_run++;
    if (n !== 3 || bus_c.instr_op !== 8'h04 || bus_c.instr_imm !== 8'h07 ||
        bus_c.instr_has_imm !== 1'b1 || bus_c.instr_pc !== 4'hF) begin
      tests_failed++;
      $display("[TB] FAIL wrap_imm: got lat=%0d op=%h imm=%h has=%b pc=%h expected lat=3 op=04 imm=07 has=1 pc=f",
               n, bus_c.instr_op, bus_c.instr_imm, bus_c.instr_has_imm, bus_c.instr_pc);
    end
    instr_ready = 1'b1;
    count_to_valid(2, n);
    instr_ready = 1'b0;
    e_op = ref_mem_c[1];
    tests_run++;
    if (bus_c.instr_pc !== 4'h1 || bus_c.instr_op !== e_op) begin
      tests_failed++;
      $display("[TB] FAIL wrap_next: got pc=%h op=%h expected pc=1 op=%h", bus_c.instr_pc, bus_c.instr_op, e_op);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    cleanup();
    load_word(8'h30, 8'h50);
    load_word(8'h31, 8'h66);
    load_word(8'h32, 8'h30);
    instr_ready = 1'b0;
    start_pc = 8'h30;
    start = 1'b1;
    count_to_valid(0, n);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (bus_a.instr_valid !== 1'b0 || bus_a.instr_pc !== 8'h00 || bus_a.instr_op !== 8'h00 || halted_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_clear: got valid=%b pc=%h op=%h halted=%b expected valid=0 pc=00 op=00 halted=0",
               bus_a.instr_valid, bus_a.instr_pc, bus_a.instr_op, halted_a);
    end
    step();
    start = 1'b1;
    count_to_valid(0, n);
    tests_run++;
    if (n !== 3 || bus_a.instr_op !== 8'h50 || bus_a.instr_imm !== 8'h66 || bus_a.instr_pc !== 8'h30) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_restart: got lat=%0d op=%h imm=%h pc=%h expected lat=3 op=50 imm=66 pc=30",
               n, bus_a.instr_op, bus_a.instr_imm, bus_a.instr_pc);
    end
  endtask

  // Continues from the instruction left presented by test_reset_mid.
  task automatic test_ld_en();
    int n;
    instr_ready = 1'b1;
    count_to_valid(0, n);
    step();
    instr_ready = 1'b0;
    tests_run++;
    if (halted_a !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL lden_halt_first: got halted=%b expected 1", halted_a);
    end
    redirect = 1'b1;
    redirect_pc = 8'h30;
    step();
    redirect = 1'b0;
    step();
    step();
    tests_run++;
    if (halted_a !== 1'b1 || bus_a.instr_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL halted_redirect_ignored: got halted=%b valid=%b expected halted=1 valid=0", halted_a, bus_a.instr_valid);
    end
    ld_en = 1'b1; start = 1'b1; start_pc = 8'h30; redirect = 1'b1;
    step();
    ld_en = 1'b0; start = 1'b0; redirect = 1'b0;
    tests_run++;
    if (halted_a !== 1'b0 || bus_a.instr_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL lden_clear: got halted=%b valid=%b expected halted=0 valid=0", halted_a, bus_a.instr_valid);
    end
    step(); step(); step();
    tests_run++;
    if (bus_a.instr_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL lden_dominates_start: got valid=%b expected 0", bus_a.instr_valid);
    end
    start = 1'b1;
    count_to_valid(0, n);
    ld_en = 1'b1;
    instr_ready = 1'b1;
    step();
    ld_en = 1'b0;
    instr_ready = 1'b0;
    tests_run++;
    if (bus_a.instr_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL lden_present: got valid=%b expected 0", bus_a.instr_valid);
    end
  endtask

  // Transaction scoreboard: the expected instruction stream is derived from the
  // loaded memory image, the current expected PC and the start/redirect/accept
  // events observed at each edge.
  task automatic test_random();
    logic [7:0] exp_pc, w, exp_imm, nxt;
    bit         exp_run, exp_halt, was_run, acc, exp_h;
    int         stall;
    cleanup();
    exp_run = 0; exp_halt = 0; stall = 0; exp_pc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tests_run++;
      if (halted_a !== exp_halt) begin
        tests_failed++; $display("[TB] FAIL rand_halted: cycle %0d got %b expected %b", cyc, halted_a, exp_halt);
      end
      if (!exp_run) begin
        tests_run++;
        if (bus_a.instr_valid !== 1'b0) begin
          tests_failed++; $display("[TB] FAIL rand_idle_valid: cycle %0d got %b expected 0", cyc, bus_a.instr_valid);
        end
      end
      was_run     = exp_run;
      instr_ready = ($urandom_range(2) != 0);
      start_pc    = 8'($urandom);
      redirect_pc = 8'($urandom);
      if (was_run) begin
        redirect = ($urandom_range(15) == 0);
        start    = ($urandom_range(19) == 0);
      end else begin
        redirect = ($urandom_range(7) == 0);
        start    = ($urandom_range(3) == 0);
      end
      acc = bus_a.instr_valid && instr_ready;
      if (was_run && acc) begin
        w       = ref_mem[exp_pc];
        exp_h   = ref_has_imm(w);
        nxt     = exp_pc + 8'd1;
        exp_imm = exp_h ? ref_mem[nxt] : 8'h00;
        tests_run++;
        if (bus_a.instr_op !== w || bus_a.instr_has_imm !== exp_h ||
            bus_a.instr_imm !== exp_imm || bus_a.instr_pc !== exp_pc) begin
          tests_failed++;
          $display("[TB] FAIL rand_instr: cycle %0d got op=%h has=%b imm=%h pc=%h expected op=%h has=%b imm=%h pc=%h",
                   cyc, bus_a.instr_op, bus_a.instr_has_imm, bus_a.instr_imm, bus_a.instr_pc,
                   w, exp_h, exp_imm, exp_pc);
        end
        if (w[7:4] == 4'd3 && !redirect) begin
          exp_run  = 0;
          exp_halt = 1;
        end else begin
          exp_pc = exp_pc + (exp_h ? 8'd2 : 8'd1);
        end
        stall = 0;
      end else if (was_run) begin
        stall++;
        if (stall > 40) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL rand_timeout: cycle %0d no instruction for %0d cycles", cyc, stall);
          start = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
          return;
        end
      end
      if (was_run && redirect) begin
        exp_pc = redirect_pc;
        stall  = 0;
      end
      if (!was_run && start) begin
        exp_run  = 1;
        exp_halt = 0;
        exp_pc   = start_pc;
      end
      step();
    end
    start = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 256; i++) begin
      load_word(8'(i), 8'($urandom));
    end
    test_basic();
    test_backpressure();
    test_redirect();
    test_out_of_range();
    test_wrap();
    test_reset_mid();
    test_ld_en();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
